// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the external SRAM controller: FSM states and default bus widths.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        WR1,
        WR2
    } state_t;

endpackage

// File: rtl/sram.sv
// Behavioural model of the 16-bit asynchronous SRAM chip, for simulation benches only.
module sram #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic [ADDR_W-1:0] ad,
    input  logic              we_n,
    input  logic              oe_n,
    input  logic              ce_n,
    inout  wire  [DATA_W-1:0] dio
);

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1] = '{default: '0};

    // The controller holds ad and dio stable for the whole we_n pulse, so
    // committing the word on the trailing edge stores the value seen while we_n was low.
    always @(posedge we_n) begin
        if (!ce_n)
            ram[ad] <= dio;
    end

    assign dio = (!ce_n && !oe_n && we_n) ? ram[ad] : 'z;

endmodule

// File: rtl/sram_ctrl.sv
// Request/response controller driving the control strobes and data bus of one external SRAM.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_f2s,
    output logic              ready,
    output logic [DATA_W-1:0] data_s2f_r,
    output logic [DATA_W-1:0] data_s2f_ur,
    output logic [ADDR_W-1:0] ad,
    output logic              we_n,
    output logic              oe_n,
    inout  wire  [DATA_W-1:0] dio_a,
    output logic              ce_a_n,
    output logic              ub_a_n,
    output logic              lb_a_n
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              we_n_reg;
    logic              oe_n_reg;
    logic              bus_en;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mem) state_next = rw ? RD1 : WR1;
            WR1:     state_next = WR2;
            WR2:     state_next = IDLE;
            RD1:     state_next = RD2;
            RD2:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are decoded from state_next so they switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            we_n_reg  <= 1'b1;
            oe_n_reg  <= 1'b1;
            bus_en    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && mem) begin
                addr_reg <= addr;
                if (!rw)
                    wdata_reg <= data_f2s;
            end
            if (state == RD2)
                rdata_reg <= dio_a;
            we_n_reg <= (state_next != WR1);
            oe_n_reg <= !(state_next == RD1 || state_next == RD2);
            bus_en   <= (state_next == WR1 || state_next == WR2);
        end
    end

    assign ready       = (state == IDLE);
    assign ad          = addr_reg;
    assign we_n        = we_n_reg;
    assign oe_n        = oe_n_reg;
    assign data_s2f_r  = rdata_reg;
    assign dio_a       = bus_en ? wdata_reg : 'z;
    assign data_s2f_ur = dio_a;
    assign ce_a_n      = 1'b0;
    assign ub_a_n      = 1'b0;
    assign lb_a_n      = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl wired to the sram model: vector table, corner sequences, random traffic vs a reference.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem;
    logic        rw;
    logic [17:0] addr;
    logic [15:0] data_f2s;
    logic        ready;
    logic [15:0] data_s2f_r;
    logic [15:0] data_s2f_ur;
    logic [17:0] ad;
    logic        we_n;
    logic        oe_n;
    wire  [15:0] dio_a;
    logic        ce_a_n;
    logic        ub_a_n;
    logic        lb_a_n;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] ref_mem [int unsigned];

    typedef struct {
        logic        mem;
        logic        rw;
        logic [17:0] addr;
        logic [15:0] din;
        logic        ready;
        logic        we_n;
        logic        oe_n;
        logic [17:0] ad;
        logic [15:0] rdata;
    } vec_t;

    vec_t vt[$];

    sram_ctrl #(.ADDR_W(18), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .mem(mem), .rw(rw), .addr(addr),
        .data_f2s(data_f2s), .ready(ready), .data_s2f_r(data_s2f_r),
        .data_s2f_ur(data_s2f_ur), .ad(ad), .we_n(we_n), .oe_n(oe_n),
        .dio_a(dio_a), .ce_a_n(ce_a_n), .ub_a_n(ub_a_n), .lb_a_n(lb_a_n)
    );

    sram #(.ADDR_W(18), .DATA_W(16)) chip_a (
        .ad(ad), .we_n(we_n), .oe_n(oe_n), .ce_n(ce_a_n), .dio(dio_a)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input logic m, input logic r, input logic [17:0] a, input logic [15:0] d);
        mem      = m;
        rw       = r;
        addr     = a;
        data_f2s = d;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic m, input logic r, input logic [17:0] a, input logic [15:0] d,
                                input logic rdy, input logic wn, input logic on,
                                input logic [17:0] ea, input logic [15:0] rd);
        vec_t v;
        v.mem = m; v.rw = r; v.addr = a; v.din = d;
        v.ready = rdy; v.we_n = wn; v.oe_n = on; v.ad = ea; v.rdata = rd;
        return v;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [17:0] a);
        if (ref_mem.exists(int'(a)))
            return ref_mem[int'(a)];
        return 16'h0000;
    endfunction

    initial begin
        int          hi_cnt;
        int          oe_cnt;
        bit          act;
        bit          wr;
        int          idx;
        logic [17:0] m_ad;
        logic [15:0] m_wd;
        logic [15:0] m_rd;
        logic        m;
        logic        r;
        logic [17:0] a;
        logic [15:0] d;

        reset = 1'b1;
        mem = 1'b0; rw = 1'b0; addr = '0; data_f2s = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_ready", ready, 1);
        chk("rst_we_n", we_n, 1);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_bus_released", dut.bus_en, 0);
        chk("rst_rdata", data_s2f_r, 0);
        chk("rst_ad", ad, 0);
        chk("rst_tied_lo", {ce_a_n, ub_a_n, lb_a_n}, 0);

        // write F0, try to disturb it during WR1, read back, write FF, read both, read unwritten top word
        vt.push_back(mk(1, 0, 18'h000F0, 16'h00F0, 0, 0, 1, 18'h000F0, 16'h0000));
        vt.push_back(mk(1, 1, 18'h3FFFF, 16'h1234, 0, 1, 1, 18'h000F0, 16'h0000));
        vt.push_back(mk(0, 0, 18'h00000, 16'h0000, 1, 1, 1, 18'h000F0, 16'h0000));
        vt.push_back(mk(1, 1, 18'h000F0, 16'h0000, 0, 1, 0, 18'h000F0, 16'h0000));
        vt.push_back(mk(0, 0, 18'h00000, 16'h0000, 0, 1, 0, 18'h000F0, 16'h0000));
        vt.push_back(mk(0, 0, 18'h00000, 16'h0000, 1, 1, 1, 18'h000F0, 16'h00F0));
        vt.push_back(mk(1, 0, 18'h000FF, 16'h00FF, 0, 0, 1, 18'h000FF, 16'h00F0));
        vt.push_back(mk(0, 0, 18'h00000, 16'h0000, 0, 1, 1, 18'h000FF, 16'h00F0));
        vt.push_back(mk(0, 0, 18'h00000, 16'h0000, 1, 1, 1, 18'h000FF, 16'h00F0));
        vt.push_back(mk(1, 1, 18'h000F0, 16'h0000, 0, 1, 0, 18'h000F0, 16'h00F0));
        vt.push_back(mk(0, 0, 18'h00000, 16'h0000, 0, 1, 0, 18'h000F0, 16'h00F0));
        vt.push_back(mk(0, 0, 18'h00000, 16'h0000, 1, 1, 1, 18'h000F0, 16'h00F0));
        vt.push_back(mk(1, 1, 18'h000FF, 16'h0000, 0, 1, 0, 18'h000FF, 16'h00F0));
        vt.push_back(mk(0, 0, 18'h00000, 16'h0000, 0, 1, 0, 18'h000FF, 16'h00F0));
        vt.push_back(mk(0, 0, 18'h00000, 16'h0000, 1, 1, 1, 18'h000FF, 16'h00FF));
        vt.push_back(mk(1, 1, 18'h3FFFF, 16'h0000, 0, 1, 0, 18'h3FFFF, 16'h00FF));
        vt.push_back(mk(0, 0, 18'h00000, 16'h0000, 0, 1, 0, 18'h3FFFF, 16'h00FF));
        vt.push_back(mk(0, 0, 18'h00000, 16'h0000, 1, 1, 1, 18'h3FFFF, 16'h0000));

        foreach (vt[i]) begin
            step(vt[i].mem, vt[i].rw, vt[i].addr, vt[i].din);
            chk($sformatf("vec%0d_ready", i), ready, vt[i].ready);
            chk($sformatf("vec%0d_we_n", i), we_n, vt[i].we_n);
            chk($sformatf("vec%0d_oe_n", i), oe_n, vt[i].oe_n);
            chk($sformatf("vec%0d_ad", i), ad, vt[i].ad);
            chk($sformatf("vec%0d_rdata", i), data_s2f_r, vt[i].rdata);
        end
        ref_mem[32'h0F0] = 16'h00F0;
        ref_mem[32'h0FF] = 16'h00FF;

        // continuous reads: one completes every third edge
        hi_cnt = 0;
        oe_cnt = 0;
        for (int k = 0; k < 9; k++) begin
            step(1, 1, 18'h000FF, 16'h0000);
            chk($sformatf("cont%0d_ready", k), ready, (k % 3 == 2));
            if (ready) hi_cnt++;
            if (!oe_n) oe_cnt++;
        end
        chk("cont_ready_count", hi_cnt, 3);
        chk("cont_oe_low_count", oe_cnt, 6);
        chk("cont_rdata", data_s2f_r, 16'h00FF);

        // reset while in WR1
        step(1, 0, 18'h00100, 16'hABCD);
        chk("mid_wr_we_n", we_n, 0);
        chk("mid_wr_dio", data_s2f_ur, 16'hABCD);
        reset = 1'b1;
        step(0, 0, 18'h00000, 16'h0000);
        reset = 1'b0;
        chk("mid_rst_we_n", we_n, 1);
        chk("mid_rst_oe_n", oe_n, 1);
        chk("mid_rst_bus", dut.bus_en, 0);
        chk("mid_rst_ready", ready, 1);
        step(0, 0, 18'h00000, 16'h0000);
        chk("post_rst_ready", ready, 1);

        // random traffic against a transaction-level reference
        act = 0; wr = 0; idx = 0;
        m_ad = '0; m_wd = '0; m_rd = '0;
        for (int i = 0; i < 400; i++) begin
            m = ($urandom_range(0, 9) < 7);
            r = 1'($urandom_range(0, 1));
            a = 18'h00200 + 18'($urandom_range(0, 7));
            d = 16'($urandom);
            if (act) begin
                if (idx == 1) begin
                    act = 0;
                    if (wr) ref_mem[int'(m_ad)] = m_wd;
                    else    m_rd = ref_rd(m_ad);
                end else begin
                    idx++;
                end
            end else if (m) begin
                act = 1; idx = 0; wr = !r; m_ad = a;
                if (!r) m_wd = d;
            end
            step(m, r, a, d);
            chk("rnd_ready", ready, !act);
            chk("rnd_we_n", we_n, !(act && wr && idx == 0));
            chk("rnd_oe_n", oe_n, !(act && !wr));
            chk("rnd_ad", ad, m_ad);
            chk("rnd_rdata", data_s2f_r, m_rd);
            chk("rnd_bus_en", dut.bus_en, act && wr);
            if (act && wr)
                chk("rnd_dio", data_s2f_ur, m_wd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
